// File: rtl/cla_pkg.sv
// Shared definitions for the carry-lookahead subtractor tile.
//   state_t     : FSM state encoding (S_IDLE / S_HAVE_M / S_CALC / S_DONE)
//   fsm_dbg_t   : snapshot of the FSM state and the status flags it decodes to
//   STRB..DONE  : bit positions on uio_in / uio_out
//   UIO_OE_MASK : uio output-enable pattern (bits 7:3 driven, 2:0 inputs)
package cla_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HAVE_M = 2'd1,
    S_CALC   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  typedef struct packed {
    state_t state;
    logic   busy;
    logic   done;
  } fsm_dbg_t;

  // uio_in bit positions
  localparam int STRB = 0;
  localparam int CLR  = 1;

  // uio_out bit positions
  localparam int OVF    = 3;
  localparam int BUSY   = 4;
  localparam int BORROW = 5;
  localparam int ZERO   = 6;
  localparam int DONE   = 7;

  localparam logic [7:0] UIO_OE_MASK = 8'hF8;

endpackage

// File: rtl/cla_adder8.sv
// Combinational carry-lookahead adder.
//   a, b : operands
//   cin  : carry in
//   sum  : a + b + cin, modulo 2^W
//   cout : carry out of the top bit
// Propagate is XOR so the same p term also forms the sum bit. Every carry
// is built as a flat sum of products over generate/propagate terms and cin,
// rather than rippling through the previous carry.
module cla_adder8 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;
  logic         c_term;
  logic         p_prod;

  assign g = a & b;
  assign p = a ^ b;

  // c[i+1] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... | p[i]..p[0]cin
  always_comb begin
    c      = '0;
    c_term = 1'b0;
    p_prod = 1'b1;
    c[0]   = cin;
    for (int i = 0; i < W; i++) begin
      c_term = 1'b0;
      p_prod = 1'b1;
      for (int j = i; j >= 0; j--) begin
        c_term = c_term | (g[j] & p_prod);
        p_prod = p_prod & p[j];
      end
      c[i+1] = c_term | (cin & p_prod);
    end
  end

  assign sum  = p ^ c[W-1:0];
  assign cout = c[W];

endmodule

// File: rtl/tt_um_cla_subtractor_seq.sv
// Sequential subtractor tile: diff = minuend - subtrahend, one operand byte
// per strobe.
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : 0 freezes the FSM and result registers; strobes are lost
//   ui_in      : operand byte (minuend first, then subtrahend)
//   uio_in     : [0] strb, [1] clr, [7:2] unused
//   uo_out     : registered difference
//   uio_out    : [7] done, [6] zero, [5] borrow, [4] busy, [3] ovf, [2:0] 0
//   uio_oe     : constant 8'hF8
//
// Strobe handshake: there is no ready signal. The source raises strb with
// ui_in already valid and holds ui_in for SYNC_STAGES+2 clocks; each
// synchronised rising edge transfers one byte. The FSM accepts a byte in
// S_IDLE, S_HAVE_M and S_DONE; an edge arriving in S_CALC is dropped, so the
// source waits for done before sending the next minuend.
module tt_um_cla_subtractor_seq
  import cla_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // Synchronisers and edge detect run regardless of ena so that a strobe
  // seen while frozen is consumed and not replayed once ena returns.
  logic [SYNC_STAGES-1:0] strb_sync;
  logic [SYNC_STAGES-1:0] clr_sync;
  logic                   prev_strb;
  logic                   sync_strb;
  logic                   sync_clr;
  logic                   strb_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strb_sync <= '0;
      clr_sync  <= '0;
      prev_strb <= 1'b0;
    end else begin
      strb_sync <= {strb_sync[SYNC_STAGES-2:0], uio_in[STRB]};
      clr_sync  <= {clr_sync[SYNC_STAGES-2:0], uio_in[CLR]};
      prev_strb <= sync_strb;
    end
  end

  assign sync_strb = strb_sync[SYNC_STAGES-1];
  assign sync_clr  = clr_sync[SYNC_STAGES-1];
  assign strb_rise = sync_strb & ~prev_strb;

  // Datapath: m - s = m + ~s + 1
  state_t           state;
  logic [WIDTH-1:0] minuend;
  logic [WIDTH-1:0] subtrahend;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             ovf_q;
  logic             zero_q;
  logic [WIDTH-1:0] sum;
  logic             cout;

  cla_adder8 #(.W(WIDTH)) u_adder (
    .a    (minuend),
    .b    (~subtrahend),
    .cin  (1'b1),
    .sum  (sum),
    .cout (cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      minuend    <= '0;
      subtrahend <= '0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else if (ena) begin
      if (sync_clr) begin
        // clr wins over a coincident strobe edge and drops any pending minuend
        state      <= S_IDLE;
        minuend    <= '0;
        subtrahend <= '0;
        diff_q     <= '0;
        borrow_q   <= 1'b0;
        ovf_q      <= 1'b0;
        zero_q     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (strb_rise) begin
              minuend <= ui_in;
              state   <= S_HAVE_M;
            end
          end
          S_HAVE_M: begin
            if (strb_rise) begin
              subtrahend <= ui_in;
              state      <= S_CALC;
            end
          end
          S_CALC: begin
            diff_q   <= sum;
            borrow_q <= ~cout;
            // signed overflow: operand signs differ and result sign left the minuend's
            ovf_q    <= (minuend[WIDTH-1] != subtrahend[WIDTH-1]) &&
                        (sum[WIDTH-1] != minuend[WIDTH-1]);
            zero_q   <= (sum == '0);
            state    <= S_DONE;
          end
          S_DONE: begin
            // results are held; only the operand registers move here
            if (strb_rise) begin
              minuend <= ui_in;
              state   <= S_HAVE_M;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  fsm_dbg_t fsm_dbg;

  always_comb begin
    fsm_dbg.state = state;
    fsm_dbg.busy  = (state == S_HAVE_M) || (state == S_CALC);
    fsm_dbg.done  = (state == S_DONE);
  end

  always_comb begin
    uio_out         = 8'h00;
    uio_out[DONE]   = fsm_dbg.done;
    uio_out[ZERO]   = zero_q;
    uio_out[BORROW] = borrow_q;
    uio_out[BUSY]   = fsm_dbg.busy;
    uio_out[OVF]    = ovf_q;
  end

  assign uo_out = diff_q;
  assign uio_oe = UIO_OE_MASK;

  logic unused_uio;
  assign unused_uio = &{1'b0, uio_in[7:2]};

endmodule
